// File: rtl/vin_gen_seq.sv
// VIN-side internal-bus sequencer for the GEN: Type-1/Type-2 cell slice fetch
// and Type-4 mailbox loads. Every output is registered from the next state.
module vin_gen_seq #(
    parameter int STROBE_CYC = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       start,
    input  logic [7:0] code_a,
    input  logic [7:0] code_b,
    input  logic [3:0] row,
    input  logic       mb_req,
    input  logic [7:0] mb_a,
    input  logic [7:0] mb_b,
    input  logic [7:0] bus_a_in,
    output logic [7:0] bus_a_out,
    output logic [7:0] bus_b_out,
    output logic       bus_oe,
    output logic       _sm,
    output logic       _sg,
    output logic       _st,
    output logic       r_wi,
    output logic [3:0] adr,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       busy,
    output logic       mb_done,
    output logic       overrun
);

    localparam int MAXC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] S_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] G_LD = CW'(GAP_CYC - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP, SM_LOW, GAP1, SG_LOW, GAP2, MB_SETUP, MB_LOW, MB_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    row_q;
    logic          cnt_done;
    logic          row_ok;

    assign cnt_done = (cnt == '0);
    assign row_ok   = (row <= 4'd9);

    // Counter holds remaining cycles minus one; reloaded on each state entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_done ? cnt : cnt - CW'(1);
        case (state)
            IDLE: begin
                if (start && row_ok) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end else if (!start && mb_req) begin
                    state_nxt = MB_SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP:    begin state_nxt = SM_LOW; cnt_nxt = S_LD; end
            SM_LOW:   if (cnt_done) begin state_nxt = GAP1;   cnt_nxt = G_LD; end
            GAP1:     if (cnt_done) begin state_nxt = SG_LOW; cnt_nxt = S_LD; end
            SG_LOW:   if (cnt_done) begin state_nxt = GAP2;   cnt_nxt = G_LD; end
            GAP2:     if (cnt_done) state_nxt = IDLE;
            MB_SETUP: begin state_nxt = MB_LOW; cnt_nxt = S_LD; end
            MB_LOW:   if (cnt_done) begin state_nxt = MB_GAP; cnt_nxt = G_LD; end
            MB_GAP:   if (cnt_done) state_nxt = IDLE;
            default:  begin state_nxt = IDLE; cnt_nxt = '0; end
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            row_q     <= '0;
            bus_a_out <= '0;
            bus_b_out <= '0;
            bus_oe    <= 1'b0;
            _sm       <= 1'b1;
            _sg       <= 1'b1;
            _st       <= 1'b1;
            r_wi      <= 1'b1;
            adr       <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            mb_done   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            r_wi      <= 1'b1;
            _sm       <= !(state_nxt == SM_LOW || state_nxt == MB_LOW);
            _sg       <= !(state_nxt == SG_LOW);
            _st       <= !(state_nxt == MB_SETUP || state_nxt == MB_LOW);
            bus_oe    <= (state_nxt == SETUP || state_nxt == SM_LOW ||
                          state_nxt == MB_SETUP || state_nxt == MB_LOW);
            busy      <= (state_nxt != IDLE);
            pix_valid <= 1'b0;
            mb_done   <= 1'b0;

            if (state == IDLE && start) begin
                row_q <= row;
                if (row_ok) begin
                    bus_a_out <= code_a;
                    bus_b_out <= code_b;
                end else begin
                    // Blank slice: hand the serializer an empty byte, no bus cycle.
                    pix_data  <= '0;
                    pix_valid <= 1'b1;
                end
            end else if (state == IDLE && mb_req) begin
                bus_a_out <= mb_a;
                bus_b_out <= mb_b;
            end

            if (state != IDLE && start)
                overrun <= 1'b1;
            if (state == SM_LOW && cnt_done)
                adr <= row_q;
            if (state == SG_LOW && cnt_done) begin
                pix_data  <= bus_a_in;
                pix_valid <= 1'b1;
            end
            if (state == MB_LOW && cnt_done)
                mb_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vin_gen_seq.sv
// Directed bench for vin_gen_seq with a simple GEN model on busA.
module tb_vin_gen_seq;

    logic       clk = 1'b0;
    logic       _rst;
    logic       start;
    logic [7:0] code_a, code_b;
    logic [3:0] row;
    logic       mb_req;
    logic [7:0] mb_a, mb_b;
    logic [7:0] bus_a_in;
    logic [7:0] bus_a_out, bus_b_out;
    logic       bus_oe, _sm, _sg, _st, r_wi;
    logic [3:0] adr;
    logic [7:0] pix_data;
    logic       pix_valid, busy, mb_done, overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] gen_byte;
    logic [7:0] nxt_a, nxt_b;
    logic [3:0] nxt_row;

    logic [31:0] v_sm, v_sg, v_st, v_oe, v_pv, v_busy, v_ov, v_md;
    logic [7:0]  a_out [32];
    logic [7:0]  b_out [32];
    logic [7:0]  pd    [32];
    logic [3:0]  ad    [32];

    // GEN returns the slice byte only while _sg is low.
    assign bus_a_in = (!_sg) ? gen_byte : 8'hFF;

    always #5 clk = ~clk;

    vin_gen_seq dut (
        .clk(clk), ._rst(_rst), .start(start), .code_a(code_a), .code_b(code_b),
        .row(row), .mb_req(mb_req), .mb_a(mb_a), .mb_b(mb_b), .bus_a_in(bus_a_in),
        .bus_a_out(bus_a_out), .bus_b_out(bus_b_out), .bus_oe(bus_oe), ._sm(_sm),
        ._sg(_sg), ._st(_st), .r_wi(r_wi), .adr(adr), .pix_data(pix_data),
        .pix_valid(pix_valid), .busy(busy), .mb_done(mb_done), .overrun(overrun)
    );

    // Cycle 0 inputs are already applied on entry; records outputs per cycle.
    task automatic run(input int n, input int s2, input int mbdrop);
        v_sm = '1; v_sg = '1; v_st = '1; v_oe = '0;
        v_pv = '0; v_busy = '0; v_ov = '0; v_md = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            v_sm[c] = _sm; v_sg[c] = _sg; v_st[c] = _st; v_oe[c] = bus_oe;
            v_pv[c] = pix_valid; v_busy[c] = busy; v_ov[c] = overrun; v_md[c] = mb_done;
            a_out[c] = bus_a_out; b_out[c] = bus_b_out; pd[c] = pix_data; ad[c] = adr;
            @(posedge clk); #1;
            if (c + 1 == s2) begin
                start = 1'b1; code_a = nxt_a; code_b = nxt_b; row = nxt_row;
            end else begin
                start = 1'b0;
            end
            if (c + 1 == mbdrop) mb_req = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++; if ({_sm, _sg, _st, r_wi} !== 4'b1111) begin errors++;
            $display("FAIL reset_strobes got %b want 1111", {_sm, _sg, _st, r_wi}); end
        checks++; if ({bus_oe, pix_valid, busy, mb_done, overrun} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b want 00000", {bus_oe, pix_valid, busy, mb_done, overrun}); end
        checks++; if ({bus_a_out, bus_b_out, pix_data, adr} !== 28'h0) begin errors++;
            $display("FAIL reset_data got %h want 0", {bus_a_out, bus_b_out, pix_data, adr}); end
    endtask

    task automatic test_fetch;
        gen_byte = 8'h7E; code_a = 8'h41; code_b = 8'h05; row = 4'd3; start = 1'b1;
        run(16, -1, -1);
        checks++; if (v_sm[15:0] !== 16'hFFC3) begin errors++; $display("FAIL fetch_sm got %h want FFC3", v_sm[15:0]); end
        checks++; if (v_sg[15:0] !== 16'hF0FF) begin errors++; $display("FAIL fetch_sg got %h want F0FF", v_sg[15:0]); end
        checks++; if (v_st[15:0] !== 16'hFFFF) begin errors++; $display("FAIL fetch_st got %h want FFFF", v_st[15:0]); end
        checks++; if (v_oe[15:0] !== 16'h003E) begin errors++; $display("FAIL fetch_oe got %h want 003E", v_oe[15:0]); end
        checks++; if (v_pv[15:0] !== 16'h1000) begin errors++; $display("FAIL fetch_pv got %h want 1000", v_pv[15:0]); end
        checks++; if (v_busy[15:0] !== 16'h3FFE) begin errors++; $display("FAIL fetch_busy got %h want 3FFE", v_busy[15:0]); end
        checks++; if ({a_out[2], b_out[2]} !== 16'h4105) begin errors++; $display("FAIL fetch_bus got %h want 4105", {a_out[2], b_out[2]}); end
        checks++; if (ad[8] !== 4'd3) begin errors++; $display("FAIL fetch_adr got %0d want 3", ad[8]); end
        checks++; if (pd[12] !== 8'h7E) begin errors++; $display("FAIL fetch_pix got %h want 7E", pd[12]); end
    endtask

    task automatic test_back_to_back;
        code_a = 8'h41; code_b = 8'h05; row = 4'd3; start = 1'b1;
        nxt_a = 8'h12; nxt_b = 8'h34; nxt_row = 4'd7;
        run(32, 14, -1);
        checks++; if (v_sm !== 32'hFFF0FFC3) begin errors++; $display("FAIL b2b_sm got %h want FFF0FFC3", v_sm); end
        checks++; if (v_sg !== 32'hFC3FF0FF) begin errors++; $display("FAIL b2b_sg got %h want FC3FF0FF", v_sg); end
        checks++; if (v_pv !== 32'h04001000) begin errors++; $display("FAIL b2b_pv got %h want 04001000", v_pv); end
        checks++; if (v_busy !== 32'h0FFFBFFE) begin errors++; $display("FAIL b2b_busy got %h want 0FFFBFFE", v_busy); end
        checks++; if (v_ov !== 32'h0) begin errors++; $display("FAIL b2b_overrun got %h want 0", v_ov); end
        checks++; if ({a_out[16], b_out[16], ad[22]} !== 20'h12347) begin errors++;
            $display("FAIL b2b_second got %h want 12347", {a_out[16], b_out[16], ad[22]}); end
    endtask

    task automatic test_overrun;
        gen_byte = 8'h99; code_a = 8'h55; code_b = 8'h66; row = 4'd2; start = 1'b1;
        nxt_a = 8'hEE; nxt_b = 8'hDD; nxt_row = 4'd9;
        run(16, 5, -1);
        checks++; if (v_ov[15:0] !== 16'hFFC0) begin errors++; $display("FAIL ovr_flag got %h want FFC0", v_ov[15:0]); end
        checks++; if (v_sm[15:0] !== 16'hFFC3) begin errors++; $display("FAIL ovr_sm got %h want FFC3", v_sm[15:0]); end
        checks++; if (v_pv[15:0] !== 16'h1000) begin errors++; $display("FAIL ovr_pv got %h want 1000", v_pv[15:0]); end
        checks++; if ({a_out[5], ad[8], pd[12]} !== 20'h55299) begin errors++;
            $display("FAIL ovr_unchanged got %h want 55299", {a_out[5], ad[8], pd[12]}); end
    endtask

    task automatic test_mailbox;
        mb_a = 8'hA5; mb_b = 8'h3C; mb_req = 1'b1;
        run(16, -1, 1);
        checks++; if (v_st[15:0] !== 16'hFFC1) begin errors++; $display("FAIL mb_st got %h want FFC1", v_st[15:0]); end
        checks++; if (v_sm[15:0] !== 16'hFFC3) begin errors++; $display("FAIL mb_sm got %h want FFC3", v_sm[15:0]); end
        checks++; if (v_md[15:0] !== 16'h0040) begin errors++; $display("FAIL mb_done got %h want 0040", v_md[15:0]); end
        checks++; if (v_busy[15:0] !== 16'h00FE) begin errors++; $display("FAIL mb_busy got %h want 00FE", v_busy[15:0]); end
        checks++; if (v_oe[15:0] !== 16'h003E) begin errors++; $display("FAIL mb_oe got %h want 003E", v_oe[15:0]); end
        checks++; if ({a_out[2], b_out[2]} !== 16'hA53C) begin errors++; $display("FAIL mb_bus got %h want A53C", {a_out[2], b_out[2]}); end
        checks++; if (v_ov[15:0] !== 16'hFFFF) begin errors++; $display("FAIL ovr_sticky got %h want FFFF", v_ov[15:0]); end
    endtask

    task automatic test_mb_and_start;
        gen_byte = 8'h7E; code_a = 8'h41; code_b = 8'h05; row = 4'd3; start = 1'b1;
        mb_a = 8'hC3; mb_b = 8'h18; mb_req = 1'b1;
        run(32, -1, 15);
        checks++; if (v_sm !== 32'hFFF0FFC3) begin errors++; $display("FAIL pri_sm got %h want FFF0FFC3", v_sm); end
        checks++; if (v_st !== 32'hFFF07FFF) begin errors++; $display("FAIL pri_st got %h want FFF07FFF", v_st); end
        checks++; if (v_sg !== 32'hFFFFF0FF) begin errors++; $display("FAIL pri_sg got %h want FFFFF0FF", v_sg); end
        checks++; if ({v_pv, v_md} !== 64'h00001000_00100000) begin errors++;
            $display("FAIL pri_pulses got %h want 0000100000100000", {v_pv, v_md}); end
        checks++; if (v_busy !== 32'h003FBFFE) begin errors++; $display("FAIL pri_busy got %h want 003FBFFE", v_busy); end
        checks++; if ({a_out[2], a_out[16]} !== 16'h41C3) begin errors++; $display("FAIL pri_bus got %h want 41C3", {a_out[2], a_out[16]}); end
    endtask

    task automatic test_row_blank;
        row = 4'd12; code_a = 8'h77; start = 1'b1;
        run(16, -1, -1);
        checks++; if ({v_sm[15:0], v_sg[15:0]} !== 32'hFFFFFFFF) begin errors++;
            $display("FAIL blank_strobes got %h want FFFFFFFF", {v_sm[15:0], v_sg[15:0]}); end
        checks++; if (v_pv[15:0] !== 16'h0002) begin errors++; $display("FAIL blank_pv got %h want 0002", v_pv[15:0]); end
        checks++; if ({pd[0], pd[1]} !== 16'h7E00) begin errors++; $display("FAIL blank_pix got %h want 7E00", {pd[0], pd[1]}); end
        checks++; if ({v_busy[15:0], v_oe[15:0]} !== 32'h0) begin errors++;
            $display("FAIL blank_busy got %h want 0", {v_busy[15:0], v_oe[15:0]}); end
    endtask

    task automatic test_reset_mid;
        gen_byte = 8'h5A; code_a = 8'h41; code_b = 8'h05; row = 4'd3; start = 1'b1;
        run(9, -1, -1);
        checks++; if (_sg !== 1'b0) begin errors++; $display("FAIL mid_pre_sg got %b want 0", _sg); end
        #2 _rst = 1'b0;
        #1;
        checks++; if ({_sg, bus_oe} !== 2'b10) begin errors++; $display("FAIL mid_async got %b want 10", {_sg, bus_oe}); end
        repeat (3) @(posedge clk);
        #1 _rst = 1'b1;
        test_reset();
        run(16, -1, -1);
        checks++; if ({v_pv[15:0], v_md[15:0], v_busy[15:0]} !== 48'h0) begin errors++;
            $display("FAIL mid_after got %h want 0", {v_pv[15:0], v_md[15:0], v_busy[15:0]}); end
        checks++; if (pd[15] !== 8'h00) begin errors++; $display("FAIL mid_pix got %h want 00", pd[15]); end
    endtask

    initial begin
        _rst = 1'b0; start = 1'b0; mb_req = 1'b0; code_a = '0; code_b = '0; row = '0;
        mb_a = '0; mb_b = '0; gen_byte = '0; nxt_a = '0; nxt_b = '0; nxt_row = '0;
        repeat (2) @(posedge clk);
        #1 _rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_overrun();
        test_mailbox();
        test_mb_and_start();
        test_row_blank();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
